// File: rtl/motor_pkg.sv
// Shared types and speed limits for the differential motor command sequencer.
package motor_pkg;

    localparam int unsigned SPD_W = 12;
    localparam int unsigned DUR_W = 16;

    localparam logic signed [SPD_W-1:0] SPD_MAX = 12'sd2047;
    localparam logic signed [SPD_W-1:0] SPD_MIN = -12'sd2047;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP_UP = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RAMP_DN = 3'd3,
        ST_ESTOP   = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [SPD_W-1:0] lft;
        logic signed [SPD_W-1:0] rght;
        logic [DUR_W-1:0]        dur;
    } cmd_t;

    // Keep speeds symmetric: -2048 has no positive counterpart.
    function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [SPD_W-1:0] v);
        return (v < SPD_MIN) ? SPD_MIN : ((v > SPD_MAX) ? SPD_MAX : v);
    endfunction

endpackage

// File: rtl/spd_slew.sv
// One-side slew limiter: moves the current speed toward the goal by at most one step.
module spd_slew
    import motor_pkg::*;
(
    input  logic signed [SPD_W-1:0] cur,
    input  logic signed [SPD_W-1:0] goal,
    input  logic [SPD_W-1:0]        step,
    output logic signed [SPD_W-1:0] spd_nxt_c
);

    logic signed [SPD_W:0] diff;
    logic signed [SPD_W:0] stp;

    // 13-bit difference so full-scale swings cannot wrap.
    assign diff = {goal[SPD_W-1], goal} - {cur[SPD_W-1], cur};
    assign stp  = {1'b0, step};

    always_comb begin
        spd_nxt_c = goal;
        if (diff > stp) begin
            spd_nxt_c = cur + step;
        end else if (diff < -stp) begin
            spd_nxt_c = cur - step;
        end
    end

endmodule

// File: rtl/motor_cmd_seq.sv
// Command sequencer: ramps both wheel speeds to a target, holds, ramps back to zero.
module motor_cmd_seq
    import motor_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 4,
    parameter int unsigned TICK_DIV  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic signed [SPD_W-1:0] cmd_lft,
    input  logic signed [SPD_W-1:0] cmd_rght,
    input  logic [DUR_W-1:0]        cmd_dur,
    input  logic                    estop,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned     DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SPD_W-1:0] STEP     = SPD_W'(RAMP_STEP);

    state_t                  state, state_nxt;
    cmd_t                    cmd_q;
    logic [DIV_W-1:0]        div_q;
    logic [DUR_W-1:0]        hold_q;
    logic                    done_nxt;
    logic                    accept, in_ramp, tick;
    logic                    at_tgt, at_zero, hold_last;
    logic signed [SPD_W-1:0] goal_l, goal_r, slew_l, slew_r;

    // Ready is combinational on estop so an estop cycle can never accept.
    assign cmd_rdy   = (state == ST_IDLE) && !estop;
    assign accept    = cmd_vld && cmd_rdy;
    assign in_ramp   = (state == ST_RAMP_UP) || (state == ST_RAMP_DN);
    assign tick      = in_ramp && (div_q == DIV_LAST);
    assign at_tgt    = (lft_spd == cmd_q.lft) && (rght_spd == cmd_q.rght);
    assign at_zero   = (lft_spd == '0) && (rght_spd == '0);
    assign hold_last = (cmd_q.dur == '0) || (hold_q == cmd_q.dur - DUR_W'(1));

    assign goal_l = (state == ST_RAMP_UP) ? cmd_q.lft  : '0;
    assign goal_r = (state == ST_RAMP_UP) ? cmd_q.rght : '0;

    spd_slew u_slew_l (.cur(lft_spd),  .goal(goal_l), .step(STEP), .spd_nxt_c(slew_l));
    spd_slew u_slew_r (.cur(rght_spd), .goal(goal_r), .step(STEP), .spd_nxt_c(slew_r));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; estop overrides every transition and kills done.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE:    if (accept)    state_nxt = ST_RAMP_UP;
            ST_RAMP_UP: if (at_tgt)    state_nxt = ST_HOLD;
            ST_HOLD:    if (hold_last) state_nxt = ST_RAMP_DN;
            ST_RAMP_DN: begin
                if (at_zero) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            ST_ESTOP:   if (!estop)    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (estop) begin
            state_nxt = ST_ESTOP;
            done_nxt  = 1'b0;
        end
    end

    // Datapath: divider, hold counter, latched command, speed outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_q    <= '0;
            hold_q   <= '0;
            cmd_q    <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else begin
            busy   <= (state_nxt != ST_IDLE);
            done   <= done_nxt;
            div_q  <= (in_ramp && !tick) ? div_q + DIV_W'(1) : '0;
            hold_q <= (state == ST_HOLD) ? hold_q + DUR_W'(1) : '0;
            if (accept) begin
                cmd_q <= '{lft: sat_spd(cmd_lft), rght: sat_spd(cmd_rght), dur: cmd_dur};
            end
            if (estop) begin
                lft_spd  <= '0;
                rght_spd <= '0;
            end else if (tick) begin
                lft_spd  <= slew_l;
                rght_spd <= slew_r;
            end
        end
    end

endmodule

// File: doc/motor_cmd_seq.md
MOTOR_CMD_SEQ -- requirements
Module: motor_cmd_seq

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 4: maximum per-tick speed change, in speed LSBs.
REQ-002 SHALL have parameter TICK_DIV, default 64: clk cycles per ramp tick, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_vld, input, 1 bit: command valid.
REQ-006 SHALL have port cmd_rdy, output, 1 bit: command ready.
REQ-007 SHALL have port cmd_lft, input, 12 bit signed: left target speed.
REQ-008 SHALL have port cmd_rght, input, 12 bit signed: right target speed.
REQ-009 SHALL have port cmd_dur, input, 16 bit unsigned: hold duration in clk cycles.
REQ-010 SHALL have port estop, input, 1 bit: emergency stop, level-sensitive.
REQ-011 SHALL have ports lft_spd and rght_spd, output, 12 bit signed each: registered speeds to the motor-drive scaling/PWM stage.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on normal command completion.

Function
REQ-014 SHALL implement states IDLE, RAMP_UP, HOLD, RAMP_DN and ESTOP.
REQ-015 SHALL drive cmd_rdy = (state==IDLE) && !estop; a command is accepted on a cycle with cmd_vld && cmd_rdy.
REQ-016 On accept, SHALL latch the targets, saturating -2048 to -2047; SHALL latch cmd_dur; SHALL clear the tick divider; SHALL enter RAMP_UP.
REQ-017 Tick divider: SHALL count 0..TICK_DIV-1 while in RAMP_UP or RAMP_DN; tick is asserted at count TICK_DIV-1, so the first tick occurs TICK_DIV cycles after accept or after HOLD exit.
REQ-018 On each tick, each side independently SHALL move toward its goal by min(RAMP_STEP, |goal-spd|); the difference SHALL be computed 13-bit signed, with no overflow.
REQ-019 RAMP_UP goal = latched target; RAMP_UP -> HOLD on the cycle both sides equal their targets; a zero target on a side leaves that side unchanged.
REQ-020 HOLD SHALL count cmd_dur cycles, then -> RAMP_DN; cmd_dur=0 SHALL go HOLD -> RAMP_DN after exactly 1 cycle; the divider SHALL be cleared on HOLD exit.
REQ-021 RAMP_DN goal = 0 on both sides; when both sides equal 0 -> IDLE, with done=1 for that one transition cycle.
REQ-022 A command with both targets 0 SHALL pass RAMP_UP in one cycle, HOLD for cmd_dur, RAMP_DN in one cycle, and then pulse done.
REQ-023 estop=1 in any state SHALL force the next state to ESTOP, force lft_spd and rght_spd to 0 on the next edge, suppress done, and abort the command.
REQ-024 ESTOP -> IDLE on the first cycle with estop=0; estop SHALL take priority over a simultaneous cmd_vld, so no accept occurs.
REQ-025 Speed outputs SHALL change only on ticks, on the estop-forced zero, or on reset; latency from tick to output is one edge (registered).

Reset
REQ-026 rst_n=0 SHALL asynchronously set state to IDLE, clear lft_spd, rght_spd, done, busy, the divider, the hold counter and the latched targets.
REQ-027 Reset asserted mid-ramp SHALL zero the speeds immediately, with no ramp-down; after release the block SHALL be ready (cmd_rdy=1, given estop=0) on the first edge.

Structure
REQ-028 SHALL place the state enum type and the 12-bit speed limits (SPD_MAX=2047, SPD_MIN=-2047) in the shared package motor_pkg.
REQ-029 The per-side step logic SHALL be one sub-module, spd_slew: current, goal and step in; next speed out; it SHALL be instantiated twice.

Verification (RAMP_STEP=4, TICK_DIV=2)
REQ-030 cmd lft=16, rght=-8, dur=10 -> lft_spd 4,8,12,16 on ticks 1-4; rght_spd -4,-8 then held; HOLD 10 cycles; ramp down to 0,0; done pulses once; busy is low the cycle after done.
REQ-031 cmd lft=6, rght=6 -> speeds 4 then 6, with no overshoot; RAMP_DN 2, then 0.
REQ-032 cmd lft=-2048 -> target latched as -2047; final held lft_spd = -2047.
REQ-033 estop raised during HOLD at lft=16 -> lft_spd=0 the next cycle, no done, cmd_rdy low until estop falls, then IDLE.
REQ-034 rst_n pulsed low during RAMP_UP -> outputs 0 asynchronously; a new cmd (lft=8, dur=0) is accepted right after release and reaches done.
REQ-035 cmd_vld held through a busy command -> the second command is accepted only in IDLE (cmd_rdy=1), exactly once, after the first done.
